// File: rtl/fetch_decode_frontend.sv
// RV32I fetch + decode front end: F holds the fetched word, D the decoded fields.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables strict illegal-encoding detection.
module fetch_decode_frontend #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic [31:0] cache_addr,
  input  logic [31:0] cache_data,
  input  logic        cache_valid,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [3:0]  dec_op,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic        dec_funct7b5,
  output logic [31:0] dec_imm,
  output logic        dec_rd_we,
  output logic        dec_rs1_use,
  output logic        dec_rs2_use,
  output logic        dec_illegal
);

  localparam logic [3:0] OP_ILLEGAL = 4'd0;
  localparam logic [3:0] OP_LUI     = 4'd1;
  localparam logic [3:0] OP_AUIPC   = 4'd2;
  localparam logic [3:0] OP_JAL     = 4'd3;
  localparam logic [3:0] OP_JALR    = 4'd4;
  localparam logic [3:0] OP_BRANCH  = 4'd5;
  localparam logic [3:0] OP_LOAD    = 4'd6;
  localparam logic [3:0] OP_STORE   = 4'd7;
  localparam logic [3:0] OP_OPIMM   = 4'd8;
  localparam logic [3:0] OP_OP      = 4'd9;
  localparam logic [3:0] OP_FENCE   = 4'd10;
  localparam logic [3:0] OP_SYSTEM  = 4'd11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic        rd_we;
    logic        rs1_use;
    logic        rs2_use;
    logic        illegal;
  } dec_t;

  logic [31:0] pc;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_valid;
  logic        d_valid;
  dec_t        d_q;
  dec_t        d_n;
  logic        f_to_d;
  logic        f_accept;

  assign cache_addr = pc;
  assign f_to_d     = f_valid && (!d_valid || dec_ready);
  assign f_accept   = cache_valid && (!f_valid || f_to_d);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        known;

  assign opc   = f_instr[6:0];
  assign f3    = f_instr[14:12];
  assign imm_i = {{20{f_instr[31]}}, f_instr[31:20]};
  assign imm_s = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
  assign imm_b = {{19{f_instr[31]}}, f_instr[31], f_instr[7],
                  f_instr[30:25], f_instr[11:8], 1'b0};
  assign imm_u = {f_instr[31:12], 12'b0};
  assign imm_j = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12],
                  f_instr[20], f_instr[30:21], 1'b0};

  always_comb begin
    d_n          = '0;
    known        = 1'b1;
    d_n.pc       = f_pc;
    d_n.instr    = f_instr;
    d_n.rd       = f_instr[11:7];
    d_n.rs1      = f_instr[19:15];
    d_n.rs2      = f_instr[24:20];
    d_n.funct3   = f3;
    d_n.funct7b5 = f_instr[30];
    unique case (1'b1)
      opc == 7'b0110111: begin
        d_n.op = OP_LUI; d_n.imm = imm_u; d_n.rd_we = 1'b1;
      end
      opc == 7'b0010111: begin
        d_n.op = OP_AUIPC; d_n.imm = imm_u; d_n.rd_we = 1'b1;
      end
      opc == 7'b1101111: begin
        d_n.op = OP_JAL; d_n.imm = imm_j; d_n.rd_we = 1'b1;
      end
      opc == 7'b1100111: begin
        d_n.op = OP_JALR; d_n.imm = imm_i;
        d_n.rd_we = 1'b1; d_n.rs1_use = 1'b1;
      end
      opc == 7'b1100011: begin
        d_n.op = OP_BRANCH; d_n.imm = imm_b;
        d_n.rs1_use = 1'b1; d_n.rs2_use = 1'b1;
      end
      opc == 7'b0000011: begin
        d_n.op = OP_LOAD; d_n.imm = imm_i;
        d_n.rd_we = 1'b1; d_n.rs1_use = 1'b1;
      end
      opc == 7'b0100011: begin
        d_n.op = OP_STORE; d_n.imm = imm_s;
        d_n.rs1_use = 1'b1; d_n.rs2_use = 1'b1;
      end
      opc == 7'b0010011: begin
        d_n.op = OP_OPIMM; d_n.imm = imm_i;
        d_n.rd_we = 1'b1; d_n.rs1_use = 1'b1;
      end
      opc == 7'b0110011: begin
        d_n.op = OP_OP; d_n.rd_we = 1'b1;
        d_n.rs1_use = 1'b1; d_n.rs2_use = 1'b1;
      end
      opc == 7'b0001111: begin
        d_n.op = OP_FENCE; d_n.imm = imm_i;
      end
      opc == 7'b1110011: begin
        d_n.op = OP_SYSTEM; d_n.imm = imm_i;
      end
      default: known = 1'b0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    if (!known)
      d_n.illegal = 1'b1;
    if (d_n.op == OP_JALR && f3 != 3'd0)
      d_n.illegal = 1'b1;
    if (d_n.op == OP_BRANCH && (f3 == 3'd2 || f3 == 3'd3))
      d_n.illegal = 1'b1;
    if (d_n.op == OP_LOAD && (f3 == 3'd3 || f3 >= 3'd6))
      d_n.illegal = 1'b1;
    if (d_n.op == OP_STORE && f3 > 3'd2)
      d_n.illegal = 1'b1;
    if (d_n.op == OP_OP && !(f_instr[31:25] == 7'h00 ||
        (f_instr[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
      d_n.illegal = 1'b1;
    if (d_n.op == OP_OPIMM && f3 == 3'd1 && f_instr[31:25] != 7'h00)
      d_n.illegal = 1'b1;
    if (d_n.op == OP_OPIMM && f3 == 3'd5 &&
        !(f_instr[31:25] == 7'h00 || f_instr[31:25] == 7'h20))
      d_n.illegal = 1'b1;
    if (d_n.illegal) begin
      d_n.op      = OP_ILLEGAL;
      d_n.imm     = '0;
      d_n.rd_we   = 1'b0;
      d_n.rs1_use = 1'b0;
      d_n.rs2_use = 1'b0;
    end
`else
    // Unknown opcodes become a harmless OPIMM that writes nothing.
    if (!known) begin
      d_n.op  = OP_OPIMM;
      d_n.imm = imm_i;
    end
`endif
    if (d_n.rd == 5'd0)
      d_n.rd_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      f_pc    <= '0;
      f_instr <= '0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      d_q     <= '0;
    end else if (jump) begin
      pc      <= jump_addr;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      if (f_accept) begin
        f_pc    <= pc;
        f_instr <= cache_data;
        pc      <= pc + 32'd4;
        f_valid <= 1'b1;
      end else if (f_to_d) begin
        f_valid <= 1'b0;
      end
      if (f_to_d) begin
        d_q     <= d_n;
        d_valid <= 1'b1;
      end else if (dec_ready) begin
        d_valid <= 1'b0;
      end
    end
  end

  assign dec_valid    = d_valid;
  assign dec_pc       = d_q.pc;
  assign dec_instr    = d_q.instr;
  assign dec_op       = d_q.op;
  assign dec_rd       = d_q.rd;
  assign dec_rs1      = d_q.rs1;
  assign dec_rs2      = d_q.rs2;
  assign dec_funct3   = d_q.funct3;
  assign dec_funct7b5 = d_q.funct7b5;
  assign dec_imm      = d_q.imm;
  assign dec_rd_we    = d_q.rd_we;
  assign dec_rs1_use  = d_q.rs1_use;
  assign dec_rs2_use  = d_q.rs2_use;
  assign dec_illegal  = d_q.illegal;

endmodule

// File: tb/tb_fetch_decode_frontend.sv
// Directed bench for fetch_decode_frontend: streaming, stall, jump, bubble, wrap.
// Instruction memory is a fixed table answered with zero delay.
module tb_fetch_decode_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] cache_addr;
  logic [31:0] cache_data;
  logic        cache_valid;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [3:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5;
  logic [31:0] dec_imm;
  logic        dec_rd_we;
  logic        dec_rs1_use;
  logic        dec_rs2_use;
  logic        dec_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode_frontend dut (
    .clk(clk), .reset(reset), .jump(jump), .jump_addr(jump_addr),
    .cache_addr(cache_addr), .cache_data(cache_data),
    .cache_valid(cache_valid), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
    .dec_funct7b5(dec_funct7b5), .dec_imm(dec_imm),
    .dec_rd_we(dec_rd_we), .dec_rs1_use(dec_rs1_use),
    .dec_rs2_use(dec_rs2_use), .dec_illegal(dec_illegal)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h00: mem = 32'h0050_0093;
      32'h04: mem = 32'h1234_50b7;
      32'h08: mem = 32'hFFFF_FFFF;
      32'h0C: mem = 32'hFE21_AE23;
      32'h10: mem = 32'hFE20_8CE3;
      32'h14: mem = 32'h0020_81B3;
      default: mem = 32'h0000_0013;
    endcase
  endfunction

  assign cache_data = mem(cache_addr);

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic [3:0]  ILL_OP  = 4'd0;
  localparam logic [31:0] ILL_IMM = 32'h0;
  localparam logic        ILL_FLG = 1'b1;
`else
  localparam logic [3:0]  ILL_OP  = 4'd8;
  localparam logic [31:0] ILL_IMM = 32'hFFFF_FFFF;
  localparam logic        ILL_FLG = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; jump = 1'b0; jump_addr = '0;
    cache_valid = 1'b1; dec_ready = 1'b1;
    step(); step();
    total++;
    if (dec_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%0b exp=0", dec_valid);
    end
    total++;
    if (cache_addr !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h exp=0", cache_addr);
    end
    total++;
    if ({dec_pc, dec_instr, dec_op, dec_imm, dec_rd_we} !== '0) begin
      bad++; $display("FAIL reset_fields pc=%h op=%0d imm=%h", dec_pc, dec_op, dec_imm);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e_pc [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    logic [3:0]  e_op [6] = '{4'd8, 4'd1, ILL_OP, 4'd7, 4'd5, 4'd9};
    logic [4:0]  e_rd [6] = '{5'd1, 5'd1, 5'd31, 5'd28, 5'd25, 5'd3};
    logic [31:0] e_imm[6] = '{32'd5, 32'h1234_5000, ILL_IMM,
                              32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0};
    logic        e_we [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        e_r2 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset = 1'b0;
    step();
    total++;
    if (dec_valid !== 1'b0 || cache_addr !== 32'h4) begin
      bad++; $display("FAIL latency_edge1 valid=%0b addr=%h exp 0/4", dec_valid, cache_addr);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== e_pc[i] || dec_instr !== mem(e_pc[i])) begin
        bad++; $display("FAIL stream_pc[%0d] valid=%0b pc=%h exp %h", i, dec_valid, dec_pc, e_pc[i]);
      end
      total++;
      if (dec_op !== e_op[i] || dec_rd !== e_rd[i] || dec_imm !== e_imm[i]) begin
        bad++; $display("FAIL stream_dec[%0d] op=%0d rd=%0d imm=%h exp %0d %0d %h",
                        i, dec_op, dec_rd, dec_imm, e_op[i], e_rd[i], e_imm[i]);
      end
      total++;
      if (dec_rd_we !== e_we[i] || dec_rs2_use !== e_r2[i]) begin
        bad++; $display("FAIL stream_use[%0d] we=%0b rs2u=%0b exp %0b %0b",
                        i, dec_rd_we, dec_rs2_use, e_we[i], e_r2[i]);
      end
      if (i == 0) begin
        total++;
        if (dec_rs1 !== 5'd0 || dec_rs1_use !== 1'b1 || dec_funct3 !== 3'd0) begin
          bad++; $display("FAIL addi_rs1 rs1=%0d use=%0b f3=%0d", dec_rs1, dec_rs1_use, dec_funct3);
        end
      end
      if (i == 2) begin
        total++;
        if (dec_illegal !== ILL_FLG) begin
          bad++; $display("FAIL illegal_flag got=%0b exp=%0b", dec_illegal, ILL_FLG);
        end
      end
      if (i == 3) begin
        total++;
        if (dec_rs1 !== 5'd3 || dec_rs2 !== 5'd2 || dec_funct3 !== 3'd2) begin
          bad++; $display("FAIL store_fields rs1=%0d rs2=%0d f3=%0d", dec_rs1, dec_rs2, dec_funct3);
        end
      end
    end
  endtask

  task automatic test_stall();
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h14 || dec_instr !== 32'h0020_81B3 ||
          dec_op !== 4'd9 || cache_addr !== 32'h1C) begin
        bad++; $display("FAIL stall_hold[%0d] v=%0b pc=%h op=%0d addr=%h", k, dec_valid, dec_pc, dec_op, cache_addr);
      end
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h18 + 32'(4 * k)) begin
        bad++; $display("FAIL stall_release[%0d] v=%0b pc=%h exp %h", k, dec_valid, dec_pc, 32'h18 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_jump();
    dec_ready = 1'b0;
    step();
    total++;
    if (dec_pc !== 32'h20 || dec_valid !== 1'b1) begin
      bad++; $display("FAIL jump_prestall pc=%h v=%0b exp 20/1", dec_pc, dec_valid);
    end
    jump = 1'b1; jump_addr = 32'h100;
    step();
    jump = 1'b0; dec_ready = 1'b1;
    total++;
    if (dec_valid !== 1'b0 || cache_addr !== 32'h100) begin
      bad++; $display("FAIL jump_flush v=%0b addr=%h exp 0/100", dec_valid, cache_addr);
    end
    step();
    total++;
    if (dec_valid !== 1'b0) begin
      bad++; $display("FAIL jump_gap v=%0b exp 0", dec_valid);
    end
    step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin
      bad++; $display("FAIL jump_first v=%0b pc=%h exp 100", dec_valid, dec_pc);
    end
    step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h104) begin
      bad++; $display("FAIL jump_second v=%0b pc=%h exp 104", dec_valid, dec_pc);
    end
  endtask

  task automatic test_bubble();
    cache_valid = 1'b0;
    step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h108 || cache_addr !== 32'h10C) begin
      bad++; $display("FAIL bubble_drain v=%0b pc=%h addr=%h", dec_valid, dec_pc, cache_addr);
    end
    step();
    cache_valid = 1'b1;
    total++;
    if (dec_valid !== 1'b0 || cache_addr !== 32'h10C) begin
      bad++; $display("FAIL bubble_1 v=%0b addr=%h exp 0/10c", dec_valid, cache_addr);
    end
    step();
    total++;
    if (dec_valid !== 1'b0) begin
      bad++; $display("FAIL bubble_2 v=%0b exp 0", dec_valid);
    end
    step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h10C) begin
      bad++; $display("FAIL bubble_resume v=%0b pc=%h exp 10c", dec_valid, dec_pc);
    end
    step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'h110) begin
      bad++; $display("FAIL bubble_next v=%0b pc=%h exp 110", dec_valid, dec_pc);
    end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    step(); step();
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC || cache_addr !== 32'h4) begin
      bad++; $display("FAIL wrap_top v=%0b pc=%h addr=%h", dec_valid, dec_pc, cache_addr);
    end
    step();
    total++;
    if (dec_pc !== 32'h0 || dec_op !== 4'd8 || dec_imm !== 32'd5) begin
      bad++; $display("FAIL wrap_zero pc=%h op=%0d imm=%h exp 0/8/5", dec_pc, dec_op, dec_imm);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; jump = 1'b1; jump_addr = 32'h200;
    step();
    reset = 1'b0; jump = 1'b0;
    total++;
    if (cache_addr !== 32'h0 || dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_op !== 4'd0) begin
      bad++; $display("FAIL reset_over_jump addr=%h v=%0b pc=%h op=%0d", cache_addr, dec_valid, dec_pc, dec_op);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_bubble();
    test_wrap();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
